// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with double-buffered digit values and
// anode guard gaps. Define DISPLAY_SCAN_LZB_EN to enable leading-zero blanking.
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned GUARD_CYCLES = 500,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wr_valid,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  nibble_out,
    output logic [3:0]  an_out,
    output logic        dp_out,
    output logic [1:0]  digit_idx,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST =
        CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      shadow_dig_q;
    logic [3:0]       shadow_dp_q;
    logic [15:0]      frame_dig_q;
    logic [3:0]       frame_dp_q;

    logic             enter_c;
    logic             load_c;
    logic             blank_c;
    logic [1:0]       enter_idx_c;
    logic [15:0]      src_dig_c;
    logic [3:0]       src_dp_c;
    logic [3:0]       enter_an_c;

    // Next digit to enter; entering digit 0 always coincides with a frame load,
    // so the new frame's values come straight from the shadow register.
    always_comb begin
        enter_idx_c = (state_q == IDLE) ? 2'd0 : digit_idx + 2'd1;
        load_c      = (enter_idx_c == 2'd0);
        src_dig_c   = load_c ? shadow_dig_q : frame_dig_q;
        src_dp_c    = load_c ? shadow_dp_q  : frame_dp_q;
        enter_an_c  = ~(4'b0001 << enter_idx_c);
        case (state_q)
            IDLE:    enter_c = 1'b1;
            DRIVE:   enter_c = !HAS_GUARD && (cnt_q == DRIVE_LAST);
            GUARD:   enter_c = (cnt_q == GUARD_LAST);
            default: enter_c = 1'b0;
        endcase
    end

`ifdef DISPLAY_SCAN_LZB_EN
    logic [15:0] lead_c;

    // Digit is dark when it and every more-significant digit are zero and its dp is off.
    always_comb begin
        lead_c  = src_dig_c >> {enter_idx_c, 2'b00};
        blank_c = (enter_idx_c != 2'd0) && (lead_c == 16'h0000) && !src_dp_c[enter_idx_c];
    end
`else
    assign blank_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            frame_dig_q  <= '0;
            frame_dp_q   <= '0;
            nibble_out   <= 4'h0;
            an_out       <= 4'hf;
            dp_out       <= 1'b1;
            digit_idx    <= 2'd0;
            frame_start  <= 1'b0;
        end else begin
            if (wr_valid) begin
                shadow_dig_q <= digits_in;
                shadow_dp_q  <= dp_in;
            end
            frame_start <= 1'b0;
            if (!enable) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                digit_idx <= 2'd0;
                an_out    <= 4'hf;
                dp_out    <= 1'b1;
            end else if (enter_c) begin
                state_q    <= DRIVE;
                cnt_q      <= '0;
                digit_idx  <= enter_idx_c;
                nibble_out <= src_dig_c[{enter_idx_c, 2'b00} +: 4];
                dp_out     <= ~src_dp_c[enter_idx_c];
                an_out     <= blank_c ? 4'hf : enter_an_c;
                if (load_c) begin
                    frame_dig_q <= shadow_dig_q;
                    frame_dp_q  <= shadow_dp_q;
                    frame_start <= 1'b1;
                end
            end else if ((state_q == DRIVE) && (cnt_q == DRIVE_LAST)) begin
                state_q <= GUARD;
                cnt_q   <= '0;
                an_out  <= 4'hf;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
